// File: rtl/pktgen_pkg.sv
// -----------------------------------------------------------------------------
// pktgen_pkg
// Shared definitions for the AXI4-Stream packet generator.
//   - Stream width constants (DATA_WIDTH / KEEP_WIDTH)
//   - TDATA field bit positions and widths
//   - FSM state type
// Optional feature macro used by the users of this package: PKTGEN_TIMESTAMP_EN
// -----------------------------------------------------------------------------
package pktgen_pkg;

   localparam int DATA_WIDTH = 512;
   localparam int KEEP_WIDTH = DATA_WIDTH / 8;

   // TDATA field layout
   localparam int SEQ_LSB    = 0;
   localparam int SEQ_WIDTH  = 64;
   localparam int BEAT_LSB   = 64;
   localparam int BEAT_WIDTH = 16;
   localparam int TS_LSB     = 80;
   localparam int TS_WIDTH   = 64;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage : pktgen_pkg

// File: rtl/pktgen_beat_former.sv
// -----------------------------------------------------------------------------
// pktgen_beat_former
// Purely combinational packing of one stream beat.
//   [63:0]   packet sequence number
//   [79:64]  beat index within the packet
//   [143:80] timestamp on beat 0 only (PKTGEN_TIMESTAMP_EN), otherwise 0
//   all other bits 0
// Ports:
//   packet_seq  in  64          sequence number of the packet being sent
//   beat_idx    in  16          beat index within the packet
//   timestamp   in  64          latched packet timestamp (PKTGEN_TIMESTAMP_EN only)
//   tdata       out DATA_WIDTH  packed beat
// -----------------------------------------------------------------------------
module pktgen_beat_former #(
   parameter int DATA_WIDTH = 512
) (
   input  logic [63:0]           packet_seq,
   input  logic [15:0]           beat_idx,
`ifdef PKTGEN_TIMESTAMP_EN
   input  logic [63:0]           timestamp,
`endif
   output logic [DATA_WIDTH-1:0] tdata
);
   import pktgen_pkg::*;

   always_comb begin
      tdata                        = '0;
      tdata[SEQ_LSB  +: SEQ_WIDTH]  = packet_seq;
      tdata[BEAT_LSB +: BEAT_WIDTH] = beat_idx;
`ifdef PKTGEN_TIMESTAMP_EN
      // Only the first beat of a packet carries the timestamp.
      if (beat_idx == 16'd0) begin
         tdata[TS_LSB +: TS_WIDTH] = timestamp;
      end
`endif
   end

endmodule : pktgen_beat_former

// File: rtl/axis_packet_gen.sv
// -----------------------------------------------------------------------------
// axis_packet_gen
// Per-channel AXI4-Stream frame generator. A start pulse launches a run of
// packet_count fixed-length packets of PACKET_BEATS beats each, sent back to
// back with no idle cycles (other than those forced by TREADY).
// Optional feature macro: PKTGEN_TIMESTAMP_EN (adds a free-running cycle
// counter whose value is stamped into beat 0 of every packet).
// Ports:
//   clk           in   1    clock
//   resetn        in   1    synchronous, active-low reset
//   packet_count  in   64   packets to send, sampled with start in IDLE
//   start         in   1    single-cycle launch pulse
//   busy          out  1    run in progress
//   packets_sent  out  64   packets completed in current/last run
//   AXIS_TDATA    out  DATA_WIDTH  stream data
//   AXIS_TKEEP    out  DATA_WIDTH/8 all ones
//   AXIS_TLAST    out  1    last beat of a packet
//   AXIS_TVALID   out  1    stream valid
//   AXIS_TREADY   in   1    stream ready
// -----------------------------------------------------------------------------
module axis_packet_gen #(
   parameter int DATA_WIDTH   = 512,
   parameter int PACKET_BEATS = 16
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [63:0]             packet_count,
   input  logic                    start,
   output logic                    busy,
   output logic [63:0]             packets_sent,
   output logic [DATA_WIDTH-1:0]   AXIS_TDATA,
   output logic [DATA_WIDTH/8-1:0] AXIS_TKEEP,
   output logic                    AXIS_TLAST,
   output logic                    AXIS_TVALID,
   input  logic                    AXIS_TREADY
);
   import pktgen_pkg::*;

   localparam logic [15:0] LAST_BEAT = 16'(PACKET_BEATS - 1);

   state_t      state_q, state_d;
   logic [63:0] remaining_q, remaining_d;
   logic [63:0] packet_seq_q, packet_seq_d;
   logic [63:0] packets_sent_q, packets_sent_d;
   logic [15:0] beat_idx_q, beat_idx_d;

   logic        last_beat;
   logic        beat_fire;

   assign last_beat = (beat_idx_q == LAST_BEAT);
   // TVALID is exactly "in RUN", so a transfer only needs TREADY.
   assign beat_fire = (state_q == RUN) && AXIS_TREADY;

   // ---------------------------------------------------------------------
   // FSM next state / datapath
   // ---------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      remaining_d    = remaining_q;
      packet_seq_d   = packet_seq_q;
      packets_sent_d = packets_sent_q;
      beat_idx_d     = beat_idx_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               // Any accepted start clears the completion count, even a
               // zero-length request that never leaves IDLE.
               packets_sent_d = '0;
               if (packet_count != 64'd0) begin
                  remaining_d  = packet_count;
                  packet_seq_d = '0;
                  beat_idx_d   = '0;
                  state_d      = RUN;
               end
            end
         end
         RUN: begin
            if (beat_fire) begin
               if (last_beat) begin
                  beat_idx_d     = '0;
                  packet_seq_d   = packet_seq_q + 64'd1;
                  packets_sent_d = packets_sent_q + 64'd1;
                  remaining_d    = remaining_q - 64'd1;
                  if (remaining_q == 64'd1) begin
                     state_d = IDLE;
                  end
               end else begin
                  beat_idx_d = beat_idx_q + 16'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q        <= IDLE;
         remaining_q    <= '0;
         packet_seq_q   <= '0;
         packets_sent_q <= '0;
         beat_idx_q     <= '0;
      end else begin
         state_q        <= state_d;
         remaining_q    <= remaining_d;
         packet_seq_q   <= packet_seq_d;
         packets_sent_q <= packets_sent_d;
         beat_idx_q     <= beat_idx_d;
      end
   end

`ifdef PKTGEN_TIMESTAMP_EN
   // ---------------------------------------------------------------------
   // Timestamp: latched on the edge that makes beat 0 visible, using the
   // counter's next value, so the stamp equals the counter during the first
   // cycle beat 0 is presented and stays frozen through any stall.
   // ---------------------------------------------------------------------
   logic [63:0] ts_cnt_q, ts_cnt_d;
   logic [63:0] ts_q, ts_d;

   always_comb begin
      ts_cnt_d = ts_cnt_q + 64'd1;
      ts_d     = ts_q;
      if ((state_d == RUN) && ((state_q == IDLE) || (beat_fire && last_beat))) begin
         ts_d = ts_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ts_cnt_q <= '0;
         ts_q     <= '0;
      end else begin
         ts_cnt_q <= ts_cnt_d;
         ts_q     <= ts_d;
      end
   end
`endif

   // ---------------------------------------------------------------------
   // Stream outputs. TDATA is formed from registered state only, so it is
   // inherently stable while a beat is stalled.
   // ---------------------------------------------------------------------
   pktgen_beat_former #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_beat_former (
      .packet_seq (packet_seq_q),
      .beat_idx   (beat_idx_q),
`ifdef PKTGEN_TIMESTAMP_EN
      .timestamp  (ts_q),
`endif
      .tdata      (AXIS_TDATA)
   );

   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_keep
         assign AXIS_TKEEP[gi] = 1'b1;
      end
   endgenerate

   assign busy         = (state_q == RUN);
   assign AXIS_TVALID  = (state_q == RUN);
   // Gated with RUN so a one-beat configuration does not show TLAST in IDLE.
   assign AXIS_TLAST   = (state_q == RUN) && last_beat;
   assign packets_sent = packets_sent_q;

endmodule : axis_packet_gen

// File: tb/tb_axis_packet_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_packet_gen
// Directed bench for axis_packet_gen with PACKET_BEATS=4. Inputs are driven and
// outputs sampled on the falling clock edge. Optional: PKTGEN_TIMESTAMP_EN.
// -----------------------------------------------------------------------------
module tb_axis_packet_gen;

   localparam int PB = 4;
`ifdef PKTGEN_TIMESTAMP_EN
   localparam int ZERO_LSB = 144;
`else
   localparam int ZERO_LSB = 80;
`endif

   logic         clk = 1'b0;
   logic         resetn;
   logic [63:0]  packet_count;
   logic         start;
   logic         busy;
   logic [63:0]  packets_sent;
   logic [511:0] tdata;
   logic [63:0]  tkeep;
   logic         tlast;
   logic         tvalid;
   logic         tready;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axis_packet_gen #(
      .DATA_WIDTH   (512),
      .PACKET_BEATS (PB)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .packet_count (packet_count),
      .start        (start),
      .busy         (busy),
      .packets_sent (packets_sent),
      .AXIS_TDATA   (tdata),
      .AXIS_TKEEP   (tkeep),
      .AXIS_TLAST   (tlast),
      .AXIS_TVALID  (tvalid),
      .AXIS_TREADY  (tready)
   );

   // -------------------------------------------------------------------
   task automatic test_reset();
      resetn = 1'b0; start = 1'b0; packet_count = '0; tready = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
      n_checks++; if (packets_sent !== 64'd0) begin n_fail++; $display("FAIL reset_sent got %0d want 0", packets_sent); end
      n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %0b want 0", tvalid); end
      n_checks++; if (tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %0b want 0", tlast); end
      n_checks++; if (tkeep !== {64{1'b1}}) begin n_fail++; $display("FAIL reset_tkeep got %h want all ones", tkeep); end
      resetn = 1'b1;
      @(negedge clk);
      $display("reset: busy=%0b tvalid=%0b sent=%0d", busy, tvalid, packets_sent);
   endtask

   // -------------------------------------------------------------------
   task automatic test_basic();
      int k = 0;
      bit done = 0;
      tready = 1'b1;
      packet_count = 64'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (tvalid !== 1'b1) begin n_fail++; $display("FAIL basic_latency tvalid got %0b want 1", tvalid); end
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         if (tvalid) begin
            $display("basic beat %0d: seq=%0d beat=%0d tlast=%0b", k, tdata[63:0], tdata[79:64], tlast);
            n_checks++; if (tdata[63:0] !== 64'(k / PB)) begin n_fail++; $display("FAIL basic_seq beat %0d got %0d want %0d", k, tdata[63:0], k / PB); end
            n_checks++; if (tdata[79:64] !== 16'(k % PB)) begin n_fail++; $display("FAIL basic_beat beat %0d got %0d want %0d", k, tdata[79:64], k % PB); end
            n_checks++; if (tlast !== ((k % PB) == PB - 1)) begin n_fail++; $display("FAIL basic_tlast beat %0d got %0b want %0b", k, tlast, (k % PB) == PB - 1); end
            n_checks++; if ((tdata >> ZERO_LSB) !== '0) begin n_fail++; $display("FAIL basic_zero_bits beat %0d got %h want 0", k, tdata >> ZERO_LSB); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy beat %0d got 0 want 1", k); end
            k++;
            @(negedge clk);
         end else begin
            done = 1;
         end
      end
      n_checks++; if (k !== 12) begin n_fail++; $display("FAIL basic_beat_count got %0d want 12", k); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %0b want 0", busy); end
      n_checks++; if (packets_sent !== 64'd3) begin n_fail++; $display("FAIL basic_sent got %0d want 3", packets_sent); end
   endtask

   // -------------------------------------------------------------------
   task automatic test_zero_count();
      packet_count = 64'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (packets_sent !== 64'd0) begin n_fail++; $display("FAIL zero_sent got %0d want 0", packets_sent); end
      for (int cyc = 0; cyc < 5; cyc++) begin
         n_checks++; if (busy !== 1'b0 || tvalid !== 1'b0) begin n_fail++; $display("FAIL zero_idle cycle %0d got busy=%0b tvalid=%0b want 0/0", cyc, busy, tvalid); end
         @(negedge clk);
      end
      $display("zero count: busy=%0b sent=%0d", busy, packets_sent);
   endtask

   // -------------------------------------------------------------------
   task automatic test_backpressure();
      int k = 0;
      bit pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      bit stalled = 0;
      logic [511:0] prev_data = '0;
      logic prev_last = 1'b0;
      packet_count = 64'd2; start = 1'b1; tready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (!tvalid) break;
         if (stalled) begin
            n_checks++; if (tdata !== prev_data || tlast !== prev_last) begin n_fail++; $display("FAIL bp_stable cycle %0d got seq=%0d beat=%0d last=%0b want seq=%0d beat=%0d last=%0b", cyc, tdata[63:0], tdata[79:64], tlast, prev_data[63:0], prev_data[79:64], prev_last); end
         end
         tready = pattern[cyc % 4];
         if (tready) begin
            $display("bp transfer %0d: seq=%0d beat=%0d tlast=%0b", k, tdata[63:0], tdata[79:64], tlast);
            n_checks++; if (tdata[63:0] !== 64'(k / PB) || tdata[79:64] !== 16'(k % PB)) begin n_fail++; $display("FAIL bp_data transfer %0d got seq=%0d beat=%0d want seq=%0d beat=%0d", k, tdata[63:0], tdata[79:64], k / PB, k % PB); end
            n_checks++; if (tlast !== ((k % PB) == PB - 1)) begin n_fail++; $display("FAIL bp_tlast transfer %0d got %0b", k, tlast); end
            k++;
         end
         stalled   = !tready;
         prev_data = tdata;
         prev_last = tlast;
         @(negedge clk);
      end
      tready = 1'b1;
      n_checks++; if (k !== 2 * PB) begin n_fail++; $display("FAIL bp_transfer_count got %0d want %0d", k, 2 * PB); end
      n_checks++; if (packets_sent !== 64'd2) begin n_fail++; $display("FAIL bp_sent got %0d want 2", packets_sent); end
   endtask

   // -------------------------------------------------------------------
   task automatic test_start_during_run();
      int k = 0;
      tready = 1'b1;
      packet_count = 64'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (!tvalid) break;
         if (k == 3) begin start = 1'b1; packet_count = 64'd100; end
         else start = 1'b0;
         k++;
         @(negedge clk);
      end
      start = 1'b0;
      $display("start during run: transfers=%0d sent=%0d", k, packets_sent);
      n_checks++; if (k !== 2 * PB) begin n_fail++; $display("FAIL sdr_transfer_count got %0d want %0d", k, 2 * PB); end
      n_checks++; if (packets_sent !== 64'd2) begin n_fail++; $display("FAIL sdr_sent got %0d want 2", packets_sent); end
      repeat (2) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sdr_busy_after got %0b want 0", busy); end
   endtask

   // -------------------------------------------------------------------
   task automatic test_reset_mid();
      int k = 0;
      tready = 1'b1;
      packet_count = 64'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // beats 0 and 1 transfer, reset asserted while beat 2 is presented
      repeat (2) @(negedge clk);
      n_checks++; if (tvalid !== 1'b1 || tdata[79:64] !== 16'd2) begin n_fail++; $display("FAIL rm_at_beat2 got tvalid=%0b beat=%0d want 1/2", tvalid, tdata[79:64]); end
      resetn = 1'b0;
      @(negedge clk);
      n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL rm_tvalid got %0b want 0", tvalid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy got %0b want 0", busy); end
      n_checks++; if (packets_sent !== 64'd0) begin n_fail++; $display("FAIL rm_sent got %0d want 0", packets_sent); end
      resetn = 1'b1;
      @(negedge clk);
      packet_count = 64'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      $display("restart after reset: seq=%0d beat=%0d", tdata[63:0], tdata[79:64]);
      n_checks++; if (tvalid !== 1'b1 || tdata[63:0] !== 64'd0 || tdata[79:64] !== 16'd0) begin n_fail++; $display("FAIL rm_restart got tvalid=%0b seq=%0d beat=%0d want 1/0/0", tvalid, tdata[63:0], tdata[79:64]); end
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (!tvalid) break;
         k++;
         @(negedge clk);
      end
      n_checks++; if (k !== PB || packets_sent !== 64'd1) begin n_fail++; $display("FAIL rm_restart_run got beats=%0d sent=%0d want %0d/1", k, packets_sent, PB); end
   endtask

`ifdef PKTGEN_TIMESTAMP_EN
   // -------------------------------------------------------------------
   task automatic test_timestamp();
      logic [63:0] ts0;
      logic [63:0] ts1 = '0;
      bit got1 = 0;
      packet_count = 64'd2; start = 1'b1; tready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      ts0 = tdata[143:80];
      n_checks++; if (ts0 === 64'd0) begin n_fail++; $display("FAIL ts_first got 0 want nonzero"); end
      for (int cyc = 0; cyc < 5; cyc++) begin
         n_checks++; if (tdata[143:80] !== ts0 || tdata[79:64] !== 16'd0) begin n_fail++; $display("FAIL ts_stall cycle %0d got ts=%0d beat=%0d want ts=%0d beat=0", cyc, tdata[143:80], tdata[79:64], ts0); end
         @(negedge clk);
      end
      tready = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (!tvalid) break;
         if (tdata[79:64] != 16'd0) begin
            n_checks++; if (tdata[143:80] !== 64'd0) begin n_fail++; $display("FAIL ts_nonzero_beat beat %0d got %0d want 0", tdata[79:64], tdata[143:80]); end
         end else if (tdata[63:0] == 64'd1 && !got1) begin
            ts1 = tdata[143:80];
            got1 = 1;
         end
         @(negedge clk);
      end
      $display("timestamp: ts0=%0d ts1=%0d", ts0, ts1);
      n_checks++; if (!got1 || ts1 < ts0 + 64'(PB)) begin n_fail++; $display("FAIL ts_second got %0d want >= %0d", ts1, ts0 + 64'(PB)); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_zero_count();
      test_backpressure();
      test_start_during_run();
      test_reset_mid();
`ifdef PKTGEN_TIMESTAMP_EN
      test_timestamp();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_axis_packet_gen
